// File: rtl/cpu_test_pkg.sv
// Shared definitions for the CPU run monitor: FSM state encoding and probe slicing helper.
package cpu_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } run_state_e;

  // LSB position of channel idx inside a packed probe/expect bus.
  function automatic int unsigned probe_lsb(input int unsigned idx, input int unsigned xlen);
    return idx * xlen;
  endfunction

endpackage

// File: rtl/halt_detector.sv
// Flags a halted core once its PC has stayed unchanged for HALT_STABLE consecutive cycles.
module halt_detector
  import cpu_test_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int HALT_STABLE = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [XLEN-1:0] pc_in,
  output logic            halted
);

  localparam int SW = $clog2(HALT_STABLE);
  localparam logic [SW-1:0] STABLE_MAX = SW'(HALT_STABLE - 1);

  logic [XLEN-1:0] prev_pc_q, prev_pc_d;
  logic            prev_valid_q, prev_valid_d;
  logic [SW-1:0]   stable_q, stable_d;

  // Without a valid previous PC (first enabled cycle) the PC counts as changed.
  always_comb begin
    prev_pc_d    = prev_pc_q;
    prev_valid_d = prev_valid_q;
    stable_d     = stable_q;
    if (enable) begin
      prev_pc_d    = pc_in;
      prev_valid_d = 1'b1;
      if (prev_valid_q && (pc_in == prev_pc_q)) begin
        stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + SW'(1);
      end else begin
        stable_d = '0;
      end
    end else begin
      prev_pc_d    = '0;
      prev_valid_d = 1'b0;
      stable_d     = '0;
    end
    halted = enable && (stable_d == STABLE_MAX);
  end

  // Previous-PC and stability counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
      stable_q     <= '0;
    end else begin
      prev_pc_q    <= prev_pc_d;
      prev_valid_q <= prev_valid_d;
      stable_q     <= stable_d;
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller for the single-cycle core: sequences core reset, bounds the run,
// detects halt and compares probed values against expectations.
module cpu_run_monitor
  import cpu_test_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_PROBES   = 3,
  parameter int RESET_CYCLES = 1,
  parameter int RUN_CYCLES   = 20,
  parameter int HALT_STABLE  = 4,
  parameter int CNT_W        = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic                       cpu_rst,
  input  logic [XLEN-1:0]            pc_in,
  input  logic [NUM_PROBES*XLEN-1:0] probe_val,
  input  logic [NUM_PROBES*XLEN-1:0] expect_val,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic [NUM_PROBES-1:0]      fail_mask,
  output logic [CNT_W-1:0]           cycle_count
);

  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(RUN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  run_state_e            state_q, state_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [CNT_W-1:0]      cycle_q, cycle_d, cycle_inc;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic [NUM_PROBES-1:0] fail_q, fail_d;
  logic [NUM_PROBES-1:0] mismatch;
  logic                  run_en;
  logic                  halted;

  assign run_en = (state_q == ST_RUN);

  halt_detector #(
    .XLEN        (XLEN),
    .HALT_STABLE (HALT_STABLE)
  ) u_halt (
    .clock  (clock),
    .reset  (reset),
    .enable (run_en),
    .pc_in  (pc_in),
    .halted (halted)
  );

  for (genvar gi = 0; gi < NUM_PROBES; gi++) begin : g_cmp
    assign mismatch[gi] = (probe_val[probe_lsb(gi, XLEN) +: XLEN] !=
                           expect_val[probe_lsb(gi, XLEN) +: XLEN]);
  end

  assign cycle_inc = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_W'(1);

  // Next-state and result-register logic.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cycle_d   = cycle_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    fail_d    = fail_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_HOLD;
          hold_d    = '0;
          cycle_d   = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          fail_d    = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_RUN: begin
        cycle_d = cycle_inc;
        // A halt seen on the budget's last cycle still counts as a clean halt.
        if (halted) begin
          state_d = ST_CHECK;
        end else if (cycle_inc >= RUN_LIMIT) begin
          state_d   = ST_CHECK;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_CHECK: begin
        fail_d  = mismatch;
        pass_d  = ~timeout_q & ~(|mismatch);
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      cycle_q   <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cycle_q   <= cycle_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      fail_q    <= fail_d;
    end
  end

  assign cpu_rst     = ~((state_q == ST_RUN) || (state_q == ST_CHECK));
  assign busy        = (state_q == ST_HOLD) || (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign done        = (state_q == ST_DONE);
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_mask   = fail_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor: directed and randomized runs against a run-level model.
module tb_cpu_run_monitor;

  localparam int XL     = 32;
  localparam int NP     = 3;
  localparam int RESETC = 3;
  localparam int RUNC   = 20;
  localparam int HALTC  = 4;
  localparam int CW     = 16;

  logic             clock;
  logic             reset;
  logic             start;
  logic             cpu_rst;
  logic [XL-1:0]    pc_in;
  logic [NP*XL-1:0] probe_val;
  logic [NP*XL-1:0] expect_val;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [NP-1:0]    fail_mask;
  logic [CW-1:0]    cycle_count;

  int checks;
  int errors;

  logic [XL-1:0] pcs [64];
  logic [XL-1:0] probes [NP];
  logic [XL-1:0] expects [NP];

  cpu_run_monitor #(
    .XLEN(XL), .NUM_PROBES(NP), .RESET_CYCLES(RESETC),
    .RUN_CYCLES(RUNC), .HALT_STABLE(HALTC), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .cpu_rst(cpu_rst),
    .pc_in(pc_in), .probe_val(probe_val), .expect_val(expect_val),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .fail_mask(fail_mask), .cycle_count(cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Run-level model: the core halts on the first cycle that closes a window of
  // HALTC identical PCs; if no such window closes within RUNC cycles it times out.
  task automatic model(output logic exp_to, output int exp_len,
                       output logic [NP-1:0] exp_mask, output logic exp_pass);
    int  halt_n;
    bit  same;
    halt_n = 0;
    for (int n = HALTC; n <= RUNC; n++) begin
      if (halt_n == 0) begin
        same = 1'b1;
        for (int j = n - HALTC + 1; j < n; j++)
          if (pcs[j] != pcs[n - HALTC]) same = 1'b0;
        if (same) halt_n = n;
      end
    end
    exp_to  = (halt_n == 0);
    exp_len = exp_to ? RUNC : halt_n;
    for (int i = 0; i < NP; i++) exp_mask[i] = (probes[i] != expects[i]);
    exp_pass = !exp_to && (exp_mask == '0);
  endtask

  task automatic run_and_check(input string tag, input bit poke_start);
    logic          exp_to, exp_pass;
    int            exp_len, hold, k;
    logic [NP-1:0] exp_mask;
    bit            rst_seen;
    model(exp_to, exp_len, exp_mask, exp_pass);
    for (int i = 0; i < NP; i++) begin
      probe_val[i*XL +: XL]  = probes[i];
      expect_val[i*XL +: XL] = expects[i];
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".busy_after_start"}, {63'd0, busy}, 64'd1);
    check({tag, ".cleared_count"}, {48'd0, cycle_count}, 64'd0);
    check({tag, ".cleared_mask"}, {61'd0, fail_mask}, 64'd0);
    hold = 0;
    while (cpu_rst === 1'b1 && hold < 10) begin
      hold++;
      tick();
    end
    check({tag, ".hold_cycles"}, 64'(hold), 64'(RESETC));
    k = 0;
    rst_seen = 1'b0;
    while (done !== 1'b1 && k < 60) begin
      if (cpu_rst !== 1'b0) rst_seen = 1'b1;
      pc_in = pcs[k];
      start = (poke_start && k == 2) ? 1'b1 : 1'b0;
      tick();
      k++;
    end
    start = 1'b0;
    check({tag, ".core_live_cycles"}, 64'(k), 64'(exp_len + 1));
    check({tag, ".no_core_reset_in_run"}, {63'd0, rst_seen}, 64'd0);
    check({tag, ".done"}, {63'd0, done}, 64'd1);
    check({tag, ".pass"}, {63'd0, pass}, {63'd0, exp_pass});
    check({tag, ".timeout"}, {63'd0, timeout}, {63'd0, exp_to});
    check({tag, ".fail_mask"}, {61'd0, fail_mask}, {61'd0, exp_mask});
    check({tag, ".cycle_count"}, {48'd0, cycle_count}, 64'(exp_len));
    check({tag, ".cpu_rst_parked"}, {63'd0, cpu_rst}, 64'd1);
    check({tag, ".busy_done"}, {63'd0, busy}, 64'd0);
    tick();
    check({tag, ".done_held"}, {63'd0, done}, 64'd1);
    check({tag, ".mask_held"}, {61'd0, fail_mask}, {61'd0, exp_mask});
  endtask

  task automatic set_probes(input logic [XL-1:0] a, input logic [XL-1:0] b, input logic [XL-1:0] c,
                            input logic [XL-1:0] ea, input logic [XL-1:0] eb, input logic [XL-1:0] ec);
    probes[0] = a;  probes[1] = b;  probes[2] = c;
    expects[0] = ea; expects[1] = eb; expects[2] = ec;
  endtask

  initial begin
    int tail_at;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    start = 1'b0;
    pc_in = '0;
    probe_val = '0;
    expect_val = '0;
    tick();
    tick();
    check("reset.cpu_rst", {63'd0, cpu_rst}, 64'd1);
    check("reset.busy", {63'd0, busy}, 64'd0);
    check("reset.done", {63'd0, done}, 64'd0);
    check("reset.pass", {63'd0, pass}, 64'd0);
    check("reset.timeout", {63'd0, timeout}, 64'd0);
    check("reset.fail_mask", {61'd0, fail_mask}, 64'd0);
    check("reset.cycle_count", {48'd0, cycle_count}, 64'd0);
    reset = 1'b1;
    tick();

    // Halt at PC 12 with all probes matching.
    for (int i = 0; i < 64; i++) pcs[i] = (i < 4) ? XL'(4 * i) : 32'd12;
    set_probes(32'd5, 32'd7, 32'd12, 32'd5, 32'd7, 32'd12);
    run_and_check("halt_pass", 1'b0);

    // Same run, channel 1 expectation wrong; start pulsed mid-run is ignored.
    set_probes(32'd5, 32'd7, 32'd12, 32'd5, 32'd8, 32'd12);
    run_and_check("halt_fail_ch1", 1'b1);

    // Free-running PC exhausts the budget.
    for (int i = 0; i < 64; i++) pcs[i] = XL'(4 * i);
    set_probes(32'd1, 32'd2, 32'd3, 32'd1, 32'd2, 32'd3);
    run_and_check("timeout", 1'b0);

    // Halt closes exactly on the last budget cycle.
    for (int i = 0; i < 64; i++) pcs[i] = (i < 17) ? XL'(4 * i) : 32'd64;
    run_and_check("halt_at_budget", 1'b0);

    // Halt would close one cycle after the budget.
    for (int i = 0; i < 64; i++) pcs[i] = (i < 18) ? XL'(4 * i) : 32'd68;
    run_and_check("halt_after_budget", 1'b0);

    // Reset asserted for two cycles in the middle of a run.
    for (int i = 0; i < 64; i++) pcs[i] = XL'(4 * i);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < RESETC + 3; i++) begin
      pc_in = pcs[i];
      tick();
    end
    check("midrun.busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    tick();
    check("midrun.cpu_rst", {63'd0, cpu_rst}, 64'd1);
    check("midrun.busy", {63'd0, busy}, 64'd0);
    check("midrun.done", {63'd0, done}, 64'd0);
    check("midrun.cycle_count", {48'd0, cycle_count}, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check("midrun.stays_idle", {63'd0, busy}, 64'd0);

    // Randomized runs with stuttering PCs and random probe mismatches.
    for (int r = 0; r < 12; r++) begin
      pcs[0] = $urandom;
      for (int i = 1; i < 64; i++) begin
        if ($urandom_range(0, 2) == 0) pcs[i] = pcs[i-1];
        else pcs[i] = pcs[i-1] + XL'(4 * $urandom_range(1, 3));
      end
      tail_at = $urandom_range(1, 40);
      for (int i = tail_at; i < 64; i++) pcs[i] = pcs[tail_at - 1];
      for (int i = 0; i < NP; i++) begin
        expects[i] = $urandom;
        probes[i]  = ($urandom_range(0, 2) == 0) ? (expects[i] ^ (32'd1 << $urandom_range(0, 31)))
                                                 : expects[i];
      end
      run_and_check($sformatf("rand%0d", r), ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
